// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   in_valid/in_ready   : request handshake (op, operand_1, operand_2)
//   out_valid/out_ready : result handshake (result)
// master = execute stage side, slave = muldiv_unit side.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, operand_1, operand_2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, operand_1, operand_2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one magnitude bit per cycle,
// followed by a one-cycle sign fix-up. Result is held until consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous kill of any in-flight or pending op
//   bus        : muldiv_unit_if.slave (request in, result out)
// Optional feature macro: MULDIV_EARLY_OUT_EN -- divide by zero, signed
// overflow and multiply-by-zero complete on the accepting edge.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | XLEN shift-add / shift-subtract iterations
// FIX   | sign correction, result select, special-case override
// DONE  | result valid, waiting for out_ready
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   op1_q;
    logic [XLEN-1:0]   mag_m;     // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] acc;       // mul: {partial hi, multiplier}; div: low half dividend -> quotient
    logic [XLEN-1:0]   rem;
    logic [CW-1:0]     cnt;
    logic              neg_res;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   result_q;

    // request decode
    logic            accept, is_div, sgn1, sgn2, in_dz, in_ovf, early;
    logic [XLEN-1:0] mag1, mag2;

    assign accept = (state == IDLE) && bus.in_valid && !flush;
    assign is_div = bus.op[2];
    assign sgn1   = bus.operand_1[XLEN-1] &&
                    (bus.op == 3'd1 || bus.op == 3'd2 || bus.op == 3'd4 || bus.op == 3'd6);
    assign sgn2   = bus.operand_2[XLEN-1] &&
                    (bus.op == 3'd1 || bus.op == 3'd4 || bus.op == 3'd6);
    assign mag1   = sgn1 ? -bus.operand_1 : bus.operand_1;
    assign mag2   = sgn2 ? -bus.operand_2 : bus.operand_2;
    assign in_dz  = is_div && (bus.operand_2 == '0);
    assign in_ovf = (bus.op == 3'd4 || bus.op == 3'd6) &&
                    (bus.operand_1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (bus.operand_2 == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = in_dz || in_ovf ||
                   (!is_div && (bus.operand_1 == '0 || bus.operand_2 == '0));
`else
    assign early = 1'b0;
`endif

    // op[1] separates REM/REMU from DIV/DIVU
    function automatic logic [XLEN-1:0] special_res(input logic [2:0] o, input logic dz,
                                                    input logic [XLEN-1:0] a);
        if (dz) return o[1] ? a : '1;
        return o[1] ? '0 : a;
    endfunction

    // one iteration step
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;   // partial remainder after the shift, XLEN+1 bits
    logic            div_ge;
    logic [XLEN-1:0] div_diff;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_m : '0)};
    assign div_shift = {rem, acc[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, mag_m};
    assign div_diff  = div_shift[XLEN-1:0] - mag_m;

    // fix-up: negate the full product so MULH* high halves come out right
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = neg_res ? -rem : rem;

    always_comb begin
        fix_res = '0;
        case (op_q)
            3'd0:                 fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:     fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:           fix_res = quo_fix;
            default:              fix_res = rem_fix;
        endcase
        if (div_zero || div_ovf)
            fix_res = special_res(op_q, div_zero, op1_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = early ? DONE : CALC;
            CALC: if (cnt == CW'(XLEN-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            op1_q    <= '0;
            mag_m    <= '0;
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q     <= bus.op;
                    op1_q    <= bus.operand_1;
                    mag_m    <= is_div ? mag2 : mag1;
                    acc      <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                    rem      <= '0;
                    cnt      <= '0;
                    neg_res  <= (bus.op[2] && bus.op[1]) ? sgn1 : (sgn1 ^ sgn2);
                    div_zero <= in_dz;
                    div_ovf  <= in_ovf;
                    if (early)
                        result_q <= (in_dz || in_ovf) ? special_res(bus.op, in_dz, bus.operand_1) : '0;
                end
                CALC: begin
                    cnt <= (cnt == CW'(XLEN-1)) ? '0 : cnt + 1'b1;
                    if (op_q[2]) begin
                        acc[XLEN-1:0] <= {acc[XLEN-2:0], div_ge};
                        rem           <= div_ge ? div_diff : div_shift[XLEN-1:0];
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                end
                FIX: result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // reference model: plain 64-bit / signed integer arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] p;
        logic [63:0] u;
        int sa, sb;
        sa = signed'(a);
        sb = signed'(b);
        u  = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0: return u[31:0];
            3'd1: begin p = 64'(sa) * 64'(sb); return p[63:32]; end
            3'd2: begin p = 64'(sa) * $signed({32'b0, b}); return p[63:32]; end
            3'd3: return u[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // edges after the accepting edge until out_valid is seen
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (op[2]) begin
            if (b == 0) return 0;
            if ((op == 3'd4 || op == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 0;
        end else if (a == 0 || b == 0) begin
            return 0;
        end
`endif
        return XLEN + 1;
    endfunction

    // called at a negedge, returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        chk("in_ready_before_issue", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.operand_1 = a;
        bus.operand_2 = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.op        = 3'($urandom);
        bus.operand_1 = $urandom;
        bus.operand_2 = $urandom;
    endtask

    task automatic wait_result(input string name, input int lat, input logic [31:0] exp);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_result"}, bus.result, exp);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_after_drain", {31'b0, bus.out_valid}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        wait_result(name, exp_lat(op, a, b), exp);
        drain();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MINV;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, held;
        logic [2:0]  op;
        int          seen;

        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.out_ready = 1'b0;

        vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{3'd4, MINV,          32'hFFFF_FFFF, MINV});
        vecs.push_back('{3'd6, MINV,          32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd7, 32'd100,       32'd0,         32'd100});
        vecs.push_back('{3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB});
        vecs.push_back('{3'd0, 32'd0,         32'd12345,     32'h0});
        vecs.push_back('{3'd3, MINV,          32'd2,         32'h1});
        vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999});
        vecs.push_back('{3'd7, 32'hFFFF_FFFF, 32'd10,        32'd5});

        // reset values while held in reset
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_result", bus.result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_res(op, a, b));
        end

        // backpressure: result held for 10 cycles, then accept one edge after drain
        issue(3'd4, 32'd1000, 32'd7);
        wait_result("bp", exp_lat(3'd4, 32'd1000, 32'd7), 32'd142);
        held = bus.result;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.result !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) seen++;
        end
        chk("bp_hold_violations", 32'(seen), 32'd0);
        drain();
        chk("bp_in_ready_after_drain", {31'b0, bus.in_ready}, 32'd1);
        issue(3'd6, 32'hFFFF_FF9C, 32'd7);
        chk("bp_next_accepted", {31'b0, bus.in_ready}, 32'd0);
        wait_result("bp_next", exp_lat(3'd6, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
        drain();

        // flush mid-CALC with a simultaneous request that must be dropped
        issue(3'd0, 32'd1234, 32'd5678);
        repeat (14) @(negedge clk);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 3'd0;
        bus.operand_1 = 32'd3;
        bus.operand_2 = 32'd4;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        run_op("after_flush", 3'd0, 32'd3, 32'd4, 32'd12);

        // async reset mid-CALC
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_mid_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rst_no_result", 32'(seen), 32'd0);
        run_op("after_reset", 3'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
